// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM state encoding,
// default clocking constants and a width helper.
package uart_tx_fifo_pkg;

    localparam int unsigned DEFAULT_CLK_HZ = 12000000;
    localparam int unsigned DEFAULT_BAUD   = 115200;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_byte_fifo.sv
// Synchronous byte FIFO with registered full/empty flags; pushes while full
// are ignored, pops while empty are ignored.
module byte_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  logic [7:0]                din_i,
    output logic [7:0]                dout_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [clog2(DEPTH):0]     count_o
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          do_push, do_pop;

    // Acceptance is judged on the registered count only, so a same-cycle pop
    // never frees room for a push arriving while full.
    assign do_push = push_i && (count_q != FULL_CNT);
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == FULL_CNT);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign count_o = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: queues bursty bytes in a FIFO and sends them
// as back-to-back frames on a registered TX line.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned CLK_HZ       = DEFAULT_CLK_HZ,
    parameter int unsigned BAUD         = DEFAULT_BAUD,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned CLKS_PER_BIT = CLK_HZ / BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_data_rdy,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       busy,
    output logic       empty,
    output logic       full,
    output logic       overflow
);

    localparam int unsigned CNT_W = (clog2(CLKS_PER_BIT) < 1) ? 1 : clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              ovf_q, ovf_d;

    logic              fifo_pop;
    logic [7:0]        fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [clog2(DEPTH):0] fifo_count;
    logic              baud_end;

    byte_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (tx_data_rdy),
        .pop_i   (fifo_pop),
        .din_i   (tx_data),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign baud_end = (baud_q == CNT_LAST);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        fifo_pop = 1'b0;
        ovf_d    = ovf_q | (tx_data_rdy & fifo_full);

        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    tx_d     = 1'b0;
                    baud_d   = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    // Chain straight into the next start bit to avoid an idle gap.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        tx_d     = 1'b0;
                        state_d  = ST_START;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign empty    = fifo_empty;
    assign full     = fifo_full;
    assign overflow = ovf_q;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Sits directly downstream of the display-string serializer, on the L3_tx_data_rdy / L3_tx_data byte stream.
- That serializer emits bytes in consecutive-cycle bursts, far faster than the serial line can carry them.
- This block buffers the bytes in a small FIFO and shifts each one out as a standard 8N1 UART frame on the board's TX pin.
- It provides back-to-back framing and overflow reporting.

Parameters:
- CLK_HZ, 12000000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate.
- DEPTH, 16, FIFO depth in bytes; must be a power of 2, minimum 2.
- CLKS_PER_BIT, CLK_HZ/BAUD (integer division, 104 at defaults), clock cycles per serial bit; derived and overridable.

Ports:
- clk  input  1  global clock.
- rst  input  1  reset, asynchronous, active-high.
- tx_data_rdy  input  1  one-cycle strobe; tx_data is valid this cycle.
- tx_data  input  8  byte to transmit.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is in flight (START/DATA/STOP).
- empty  output  1  FIFO holds no bytes.
- full  output  1  FIFO holds DEPTH bytes.
- overflow  output  1  sticky flag: a byte was dropped.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - Outputs: tx=1, busy=0, empty=1, full=0, overflow=0.
  - Internal state: FIFO pointers and count = 0, FSM = IDLE, baud counter = 0, bit index = 0.
  - Any frame in progress is truncated and all buffered bytes are discarded.
- FIFO write:
  - A byte is accepted at a rising edge when tx_data_rdy=1 and the registered count < DEPTH.
  - If count == DEPTH, the byte is dropped and overflow <= 1 (sticky until rst). This holds even if a pop occurs in the same cycle; there is no pass-through when full.
- FIFO read: a pop occurs only on the FSM load event (below).
- Simultaneous push and pop: count is unchanged and both operations take effect.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- full and empty are decoded from the registered count.
- All outputs are registered; tx is driven from a flop.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE:
    - tx=1.
    - If empty=0: pop the head into an 8-bit shift register, tx<=0, baud counter<=0, go to START.
  - START:
    - Hold tx=0 for CLKS_PER_BIT cycles.
    - Then drive shift[0], bit index<=0, go to DATA.
  - DATA:
    - Hold each bit for CLKS_PER_BIT cycles, LSB first.
    - After bit index 7, tx<=1 and go to STOP.
  - STOP:
    - Hold tx=1 for CLKS_PER_BIT cycles.
    - At the end, if FIFO is non-empty: pop immediately, tx<=0, go to START (no idle gap).
    - Otherwise go to IDLE.
- Baud counter runs 0..CLKS_PER_BIT-1 and resets on every bit boundary.
- Frame length is exactly 10*CLKS_PER_BIT cycles, so back-to-back bytes are spaced exactly 10*CLKS_PER_BIT cycles apart.
- Latency: a byte written at edge k into an empty FIFO with the FSM in IDLE produces tx=0 after edge k+1.
- busy=1 from the load edge through the last STOP cycle.
- A write arriving while busy is simply queued.

Decomposition:
- Shared include uart_defs.vh:
  - FSM state encodings (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3).
  - A clog2 constant function.
  - Default CLK_HZ and BAUD.
- One sub-module: byte_fifo, a parameterised synchronous FIFO.
  - Inputs: push, pop, din.
  - Outputs: dout, full, empty, count.
  - Same clk and asynchronous rst.
- The FSM, baud counter and shifter live in uart_tx_fifo.

Test Plan:
1. Single byte 0x41 at edge k, defaults → tx low from edge k+1 for 104 cycles, then data bits 1,0,0,0,0,0,1,0 at 104 cycles each, stop high 104 cycles; busy high 1040 cycles; empty=1 after edge k+1.
2. 8-byte burst "A12:34@" plus 0x0D on consecutive cycles → 8 contiguous frames totalling 8320 cycles with no idle between stop and next start; decoded bytes match in order; overflow=0.
3. DEPTH=16, 20 bytes on consecutive cycles starting at edge k:
   - full=1 after edge k+16; bytes at k+17..k+19 are dropped; overflow=1.
   - Exactly the first 17 bytes are transmitted, in order.
4. Push on the exact cycle full=1 while the STOP→START pop also fires → byte dropped, overflow=1, count stays DEPTH-1 after the edge.
5. Assert rst mid-DATA (bit 3 of 0x55) with 3 bytes queued → tx=1 immediately (asynchronous), busy=0, empty=1; after release no frame is emitted until a new write.
6. CLKS_PER_BIT=4 override, 2 bytes 0x00/0xFF → frames 40 cycles each, back-to-back; verify bit widths and the stop-to-start edge with no gap.
